// File: rtl/hazard_detection_unit_pkg.sv
// Shared types and constants for the ID-stage hazard detection unit.
// Holds the stall FSM state enum and the register-match helper.
package hazard_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         STALL_MAX = 2;

  // $0 is hardwired, so writes to it never create a dependency
  function automatic logic reg_match(
    input logic       we,
    input logic [4:0] wr,
    input logic       urs,
    input logic [4:0] rs,
    input logic       urt,
    input logic [4:0] rt
  );
    return we && (wr != REG_ZERO) &&
           ((urs && (rs == wr)) ||
            (urt && (rt == wr)));
  endfunction

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Pipeline-side bundle for the hazard detection unit:
// ID/EX/MEM hazard sources in, stall/flush controls and perf counters out.
interface hazard_detection_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             ID_IsBranch;
  logic             ID_IsJump;
  logic             ID_BranchTaken;
  logic             EX_RegWrite;
  logic             EX_MemRead;
  logic [4:0]       EX_WriteReg;
  logic             MEM_RegWrite;
  logic             MEM_MemRead;
  logic [4:0]       MEM_WriteReg;
  logic             HazardControl;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
    output ID_IsBranch, ID_IsJump, ID_BranchTaken,
    output EX_RegWrite, EX_MemRead, EX_WriteReg,
    output MEM_RegWrite, MEM_MemRead, MEM_WriteReg,
    input  HazardControl, PCWrite, IFIDWrite, IFIDFlush,
    input  StallCycles, FlushCount
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
    input  ID_IsBranch, ID_IsJump, ID_BranchTaken,
    input  EX_RegWrite, EX_MemRead, EX_WriteReg,
    input  MEM_RegWrite, MEM_MemRead, MEM_WriteReg,
    output HazardControl, PCWrite, IFIDWrite, IFIDFlush,
    output StallCycles, FlushCount
  );

endinterface

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating event counter used for the stall/flush perf counters.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard detection: stall FSM, IF/ID flush on taken control flow,
// and saturating stall/flush perf counters.
module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                    Clk,
  input logic                    Rst,
  hazard_detection_unit_if.slave hz
);

  state_e     state_q, state_d;
  logic [1:0] rem_q, rem_d;
  logic [1:0] need;
  logic       m_ex, m_mem;
  logic       stall, flush;

  assign m_ex  = reg_match(hz.EX_RegWrite, hz.EX_WriteReg,
                           hz.ID_UsesRs, hz.ID_Rs,
                           hz.ID_UsesRt, hz.ID_Rt);
  assign m_mem = reg_match(hz.MEM_RegWrite, hz.MEM_WriteReg,
                           hz.ID_UsesRs, hz.ID_Rs,
                           hz.ID_UsesRt, hz.ID_Rt);

  always_comb begin
    need = 2'd0;
    if (hz.ID_IsBranch && m_ex && hz.EX_MemRead)
      need = 2'(STALL_MAX);
    else if (m_ex && hz.EX_MemRead)
      need = 2'd1;
    else if (hz.ID_IsBranch && m_ex)
      need = 2'd1;
    else if (hz.ID_IsBranch && m_mem && hz.MEM_MemRead)
      need = 2'd1;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (need != 2'd0) begin
          stall = 1'b1;
          if (need > 2'd1) begin
            state_d = STALL;
            rem_d   = need - 2'd1;
          end
        end else begin
          flush = hz.ID_IsJump ||
                  (hz.ID_IsBranch && hz.ID_BranchTaken);
        end
      end
      STALL: begin
        stall = 1'b1;
        rem_d = rem_q - 2'd1;
        if (rem_q <= 2'd1) begin
          state_d = IDLE;
          rem_d   = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // reset must override the combinational IDLE decode
  assign hz.HazardControl = Rst & stall;
  assign hz.PCWrite       = ~(Rst & stall);
  assign hz.IFIDWrite     = ~(Rst & stall);
  assign hz.IFIDFlush     = Rst & flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (hz.HazardControl),
    .count (hz.StallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (hz.IFIDFlush),
    .count (hz.FlushCount)
  );

endmodule
